// File: rtl/conv_frame_sequencer.sv
// Frame-level sequencer for the padded 3x3 convolution line buffer: latches geometry,
// feeds pixels (with optional zero rows top/bottom), drains the pipeline and counts windows.
module conv_frame_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int BUFFER_LENGTH = 2000,
    parameter int KERNEL_SIZE   = 3,
    parameter int DRAIN_CYCLES  = 4,
    localparam int W            = $clog2(BUFFER_LENGTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [W-1:0]          cfg_cols,
    input  logic [W-1:0]          cfg_rows,
    input  logic                  pad_en,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic                  stall,
    output logic [DATA_WIDTH-1:0] buf_in_point,
    output logic                  buf_valid_in,
    output logic [W-1:0]          buf_frame_column_size,
    output logic [W-1:0]          buf_frame_row_size,
    input  logic                  buf_valid_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err_cfg,
    output logic [2*W-1:0]        win_count
);
    localparam int DCW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [W-1:0] MIN_DIM  = W'(KERNEL_SIZE);
    localparam logic [W-1:0] MAX_COLS = W'(BUFFER_LENGTH);
    localparam logic [W-1:0] MAX_ROWS = W'(BUFFER_LENGTH - 3);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, TOP_PAD, STREAM, BOT_PAD, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [W-1:0]          cols_q, cols_d;
    logic [W-1:0]          rows_q, rows_d;
    logic [W-1:0]          row_size_q, row_size_d;
    logic                  pad_q, pad_d;
    logic [W-1:0]          col_cnt_q, col_cnt_d;
    logic [W-1:0]          row_cnt_q, row_cnt_d;
    logic [DCW-1:0]        drain_cnt_q, drain_cnt_d;
    logic [DATA_WIDTH-1:0] pix_q, pix_d;
    logic                  push_q, push_d;
    logic                  err_q, err_d;
    logic [2*W-1:0]        win_q, win_d;

    logic cfg_legal, accept, last_col, last_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cols_q      <= '0;
            rows_q      <= '0;
            row_size_q  <= '0;
            pad_q       <= 1'b0;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            drain_cnt_q <= '0;
            pix_q       <= '0;
            push_q      <= 1'b0;
            err_q       <= 1'b0;
            win_q       <= '0;
        end else begin
            state_q     <= state_d;
            cols_q      <= cols_d;
            rows_q      <= rows_d;
            row_size_q  <= row_size_d;
            pad_q       <= pad_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            pix_q       <= pix_d;
            push_q      <= push_d;
            err_q       <= err_d;
            win_q       <= win_d;
        end
    end

    assign cfg_legal = (cfg_cols >= MIN_DIM) && (cfg_cols <= MAX_COLS) &&
                       (cfg_rows >= MIN_DIM) && (cfg_rows <= MAX_ROWS);
    assign s_ready   = (state_q == STREAM) && !stall;
    assign accept    = s_valid && s_ready;
    assign last_col  = (col_cnt_q == cols_q - W'(1));
    assign last_row  = (row_cnt_q == rows_q - W'(1));

    always_comb begin
        state_d     = state_q;
        cols_d      = cols_q;
        rows_d      = rows_q;
        row_size_d  = row_size_q;
        pad_d       = pad_q;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        drain_cnt_d = drain_cnt_q;
        pix_d       = '0;
        push_d      = 1'b0;
        err_d       = 1'b0;
        win_d       = win_q;

        // Windows are counted through the DONE cycle; IDLE holds the last frame's total.
        if (state_q != IDLE && buf_valid_out && win_q != '1)
            win_d = win_q + (2*W)'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_legal) begin
                        cols_d      = cfg_cols;
                        rows_d      = cfg_rows;
                        pad_d       = pad_en;
                        row_size_d  = cfg_rows + (pad_en ? W'(2) : W'(0));
                        win_d       = '0;
                        col_cnt_d   = '0;
                        row_cnt_d   = '0;
                        drain_cnt_d = '0;
                        state_d     = pad_en ? TOP_PAD : STREAM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            TOP_PAD, BOT_PAD: begin
                if (!stall) begin
                    push_d = 1'b1;
                    if (last_col) begin
                        col_cnt_d = '0;
                        state_d   = (state_q == TOP_PAD) ? STREAM : DRAIN;
                    end else begin
                        col_cnt_d = col_cnt_q + W'(1);
                    end
                end
            end
            STREAM: begin
                if (accept) begin
                    push_d = 1'b1;
                    pix_d  = s_data;
                    if (last_col) begin
                        col_cnt_d = '0;
                        if (last_row) begin
                            row_cnt_d = '0;
                            state_d   = pad_q ? BOT_PAD : DRAIN;
                        end else begin
                            row_cnt_d = row_cnt_q + W'(1);
                        end
                    end else begin
                        col_cnt_d = col_cnt_q + W'(1);
                    end
                end
            end
            DRAIN: begin
                if (!stall) begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        drain_cnt_d = '0;
                        state_d     = DONE;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DCW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign buf_in_point          = pix_q;
    assign buf_valid_in          = push_q;
    assign buf_frame_column_size = cols_q;
    assign buf_frame_row_size    = row_size_q;
    assign busy                  = (state_q != IDLE) && (state_q != DONE);
    assign done                  = (state_q == DONE);
    assign err_cfg               = err_q;
    assign win_count             = win_q;
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer: drives whole frames and compares the pushed
// pixel stream, timing and status outputs against hand-derived expectations.
module tb_conv_frame_sequencer;
    localparam int DW = 8;
    localparam int BL = 2000;
    localparam int W  = $clog2(BL);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  cfg_cols = '0;
    logic [W-1:0]  cfg_rows = '0;
    logic          pad_en = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          stall = 1'b0;
    logic [DW-1:0] buf_in_point;
    logic          buf_valid_in;
    logic [W-1:0]  buf_frame_column_size;
    logic [W-1:0]  buf_frame_row_size;
    logic          buf_valid_out = 1'b0;
    logic          busy, done, err_cfg;
    logic [2*W-1:0] win_count;

    conv_frame_sequencer #(
        .DATA_WIDTH(DW), .BUFFER_LENGTH(BL), .KERNEL_SIZE(3), .DRAIN_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
        .pad_en(pad_en), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .stall(stall), .buf_in_point(buf_in_point), .buf_valid_in(buf_valid_in),
        .buf_frame_column_size(buf_frame_column_size), .buf_frame_row_size(buf_frame_row_size),
        .buf_valid_out(buf_valid_out), .busy(busy), .done(done), .err_cfg(err_cfg),
        .win_count(win_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] push_q[$];
    int done_pulses = 0;
    int stall_push_viol = 0;
    logic last_stall = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-22s got %0d expected %0d ok", tag, got, exp);
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int i);
        return DW'(i * 37 + 11);
    endfunction

    // A push visible after an edge was decided with the stall value present at that edge.
    always @(posedge clk) last_stall <= stall;
    always @(negedge clk) begin
        if (buf_valid_in) begin
            push_q.push_back(buf_in_point);
            if (last_stall) stall_push_viol++;
        end
        if (done) done_pulses++;
    end

    task automatic run_frame(input int cols, input int rows, input bit pad,
                             input bit stall_on, input bit gaps,
                             input int bvo_lo, input int bvo_hi, input bit restart,
                             output int done_cyc);
        int cyc, acc, total, sready_viol, ready_after, ready_pad, mism;
        logic [DW-1:0] exp_q[$];
        total = rows * cols;
        push_q.delete();
        stall_push_viol = 0;
        @(negedge clk);
        cfg_cols = W'(cols); cfg_rows = W'(rows); pad_en = pad; start = 1'b1; s_valid = 1'b0;
        cyc = 0; acc = 0; done_cyc = -1;
        sready_viol = 0; ready_after = 0; ready_pad = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = restart && (cyc == 5);
            if (restart && cyc == 5) begin
                cfg_cols = W'(3); cfg_rows = W'(3); pad_en = !pad;
            end
            if (cyc == 1) begin
                check("busy_after_start", busy, 1);
                check("win_clear_on_start", win_count, 0);
            end
            if (done) begin
                done_cyc = cyc;
                check("busy_low_at_done", busy, 0);
            end
            stall = stall_on && (cyc % 3 == 0);
            s_valid = !gaps || ($urandom_range(0, 3) != 0);
            s_data = pix(acc);
            buf_valid_out = (cyc >= bvo_lo) && (cyc <= bvo_hi);
            #1;
            if (stall && s_ready) sready_viol++;
            if (s_ready && acc >= total) ready_after++;
            if (pad && !stall_on && s_ready && cyc <= cols) ready_pad++;
            if (s_valid && s_ready) acc++;
            if (done_cyc >= 0) break;
        end
        check("done_seen", done_cyc >= 0, 1);
        @(negedge clk);
        start = 1'b0; s_valid = 1'b0; stall = 1'b0; buf_valid_out = 1'b0;
        if (pad) repeat (cols) exp_q.push_back('0);
        for (int i = 0; i < total; i++) exp_q.push_back(pix(i));
        if (pad) repeat (cols) exp_q.push_back('0);
        mism = 0;
        for (int i = 0; i < exp_q.size() && i < push_q.size(); i++)
            if (push_q[i] !== exp_q[i]) mism++;
        check("push_count", push_q.size(), exp_q.size());
        check("push_data_mismatches", mism, 0);
        check("accepted_pixels", acc, total);
        check("push_during_stall", stall_push_viol, 0);
        check("s_ready_during_stall", sready_viol, 0);
        check("s_ready_after_last", ready_after, 0);
        check("s_ready_in_top_pad", ready_pad, 0);
        check("busy_after_done", busy, 0);
        check("col_size", buf_frame_column_size, cols);
        check("row_size", buf_frame_row_size, rows + (pad ? 2 : 0));
    endtask

    task automatic try_bad(input int cols, input int rows, input int prev_cols);
        push_q.delete();
        @(negedge clk);
        cfg_cols = W'(cols); cfg_rows = W'(rows); pad_en = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_cfg_pulse", err_cfg, 1);
        check("busy_on_bad_cfg", busy, 0);
        @(negedge clk);
        check("err_cfg_one_cycle", err_cfg, 0);
        check("busy_stays_low", busy, 0);
        check("cfg_unchanged", buf_frame_column_size, prev_cols);
        check("no_push_on_bad_cfg", push_q.size(), 0);
    endtask

    initial begin
        int dc;
        int dp;
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int dp;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid_in", buf_valid_in, 0);
        check("rst_row_size", buf_frame_row_size, 0);
        check("rst_win_count", win_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(4, 3, 1'b0, 1'b0, 1'b0, 1000, 0, 1'b0, dc);
        check("done_latency_4x3", dc, 17);

        run_frame(5, 4, 1'b1, 1'b0, 1'b0, 1000, 0, 1'b0, dc);
        check("done_latency_pad_5x4", dc, 35);

        run_frame(8, 8, 1'b0, 1'b1, 1'b1, 1000, 0, 1'b0, dc);

        try_bad(2, 5, 8);
        try_bad(5, BL - 2, 8);

        run_frame(4, 3, 1'b0, 1'b0, 1'b0, 1000, 0, 1'b1, dc);
        check("restart_ignored_lat", dc, 17);

        run_frame(3, 3, 1'b0, 1'b0, 1'b0, 8, 14, 1'b0, dc);
        check("done_latency_3x3", dc, 14);
        check("win_count_7", win_count, 7);

        // Abort a frame mid-stream with reset.
        @(negedge clk);
        cfg_cols = W'(4); cfg_rows = W'(4); pad_en = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; s_valid = 1'b1; s_data = 8'h5a; buf_valid_out = 1'b1;
        repeat (6) @(negedge clk);
        dp = done_pulses;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid_in", buf_valid_in, 0);
        check("abort_col_size", buf_frame_column_size, 0);
        check("abort_row_size", buf_frame_row_size, 0);
        check("abort_win_count", win_count, 0);
        check("abort_s_ready", s_ready, 0);
        s_valid = 1'b0; buf_valid_out = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_done", done_pulses, dp);

        run_frame(4, 4, 1'b0, 1'b0, 1'b0, 1000, 0, 1'b0, dc);
        check("post_abort_latency", dc, 21);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
- Frame-level controller in front of the padded 3x3 convolution line buffer.
- Latches the frame geometry on start and drives the buffer's pixel/valid interface from an upstream valid/ready pixel stream.
- Optionally injects one zero row above and one below the frame, so the line buffer produces "same"-size output with vertical padding.
- Honours downstream stall, drains the buffer pipeline, counts output windows and reports completion.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- BUFFER_LENGTH, 2000, maximum line length; sets the counter width W = $clog2(BUFFER_LENGTH).
- KERNEL_SIZE, 3, kernel side; also the minimum legal frame dimension.
- DRAIN_CYCLES, 4, idle cycles held after the last push so buffer-side valids can finish.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle frame start request; sampled only in IDLE.
- cfg_cols, input, W, frame column count.
- cfg_rows, input, W, frame row count.
- pad_en, input, 1, 1 = insert one zero row at the top and one at the bottom.
- s_valid, input, 1, upstream pixel valid.
- s_data, input, DATA_WIDTH, upstream pixel.
- s_ready, output, 1, upstream pixel ready.
- stall, input, 1, downstream backpressure; no pushes while high.
- buf_in_point, output, DATA_WIDTH, pixel to the line buffer.
- buf_valid_in, output, 1, push strobe to the line buffer.
- buf_frame_column_size, output, W, latched column count.
- buf_frame_row_size, output, W, latched row count, plus 2 when padding is enabled.
- buf_valid_out, input, 1, window-valid returned by the line buffer.
- busy, output, 1, frame in progress.
- done, output, 1, one-cycle pulse at frame completion.
- err_cfg, output, 1, one-cycle pulse when start is rejected.
- win_count, output, 2W, number of buf_valid_out cycles counted this frame.

Behaviour:
- Reset (asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0, including buf_frame_column_size, buf_frame_row_size and win_count.
  - Asserting rst_n low mid-frame aborts immediately: no done pulse, and the latched config is cleared.
- FSM states: IDLE, TOP_PAD, STREAM, BOT_PAD, DRAIN, DONE.
- IDLE:
  - start=1 with legal config (KERNEL_SIZE <= cfg_cols <= BUFFER_LENGTH, KERNEL_SIZE <= cfg_rows <= BUFFER_LENGTH-3):
    - latch cols/rows/pad_en; clear win_count; busy=1 from the next cycle;
    - next state is TOP_PAD if pad_en, else STREAM.
  - start=1 with illegal config: err_cfg pulses next cycle; stay in IDLE; config registers unchanged.
  - start in any other state: ignored.
- buf_frame_row_size = rows + 2*pad_en, held from the latch until the next accepted start.
- Push rule (all states):
  - buf_in_point and buf_valid_in are registered.
  - A push decided in cycle t appears at t+1; buf_valid_in is high for exactly one cycle per pixel.
  - No push occurs in a cycle where stall=1.
- TOP_PAD:
  - Push zero pixels, one per non-stalled cycle.
  - After cols pushes, go to STREAM.
  - s_ready=0 throughout.
- STREAM:
  - s_ready = !stall (combinational).
  - A pixel is accepted when s_valid & s_ready and pushed with its s_data value.
  - The column counter wraps at cols-1 and increments the row counter.
  - Acceptance of pixel rows*cols moves to BOT_PAD if pad_en, else DRAIN; s_ready drops in that same cycle.
  - A gap in s_valid produces no push and leaves the counters unchanged.
- BOT_PAD: same as TOP_PAD, then go to DRAIN.
- DRAIN:
  - Hold buf_valid_in=0 for DRAIN_CYCLES consecutive non-stalled cycles; a stall cycle does not count.
  - Then go to DONE.
- DONE: done=1 for one cycle; busy falls in that same cycle; next state is IDLE.
- win_count:
  - Increments by 1 on each cycle with buf_valid_out=1 while busy or in DONE.
  - Saturates at all-ones.
  - Holds its value in IDLE until the next accepted start.
- Simultaneous events:
  - stall rising in the cycle a STREAM pixel would have been accepted: s_ready=0, so the pixel is not consumed.
  - buf_valid_out coincident with done: counted.
- Total pushes per frame = cols*(rows + 2*pad_en), with no duplicates and no drops.

Test Plan:
- pad_en=0, cols=4, rows=3, s_valid always 1, stall=0 -> 12 pushes with data in order, buf_frame_row_size=3, done about 12+DRAIN_CYCLES+2 cycles after start, busy low afterwards.
- pad_en=1, cols=5, rows=4 -> 5 zeros, then 20 stream pixels, then 5 zeros (30 pushes); buf_frame_row_size=6; s_ready low during both pad phases.
- stall toggled every 3rd cycle plus random s_valid gaps, cols=8, rows=8 -> push sequence identical to the unstalled run; never a push while stall=1; s_ready=0 whenever stall=1.
- start with cfg_cols=2 or cfg_rows=BUFFER_LENGTH-2 -> err_cfg pulses for one cycle, busy stays 0, no pushes; a second start during an active frame is ignored.
- rst_n asserted mid-STREAM -> all outputs 0 immediately, no done; a fresh start afterwards runs a complete, correct frame.
- buf_valid_out driven high for 7 cycles, including the done cycle -> win_count=7 after done; it clears on the next accepted start.
